// File: rtl/unidade_exibicao_sequencia.sv
// Sequence playback unit for the memory game.
// Walks the jogadas memory from address 0 up to the latched limite, showing
// each entry on the LEDs for T_ON cycles followed by a T_OFF-cycle dark gap,
// then parks in final with pronto high until the next start request.
module unidade_exibicao_sequencia #(
   parameter int T_ON  = 1000,
   parameter int T_OFF = 500
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] limite,
   input  logic [3:0] dado,
   output logic [3:0] endereco,
   output logic [3:0] leds,
   output logic       exibindo,
   output logic       pronto,
   output logic [3:0] db_estado
);

   // The timer only has to reach the larger of the two terminal counts.
   localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
   localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

   typedef enum logic [2:0] {
      INICIAL = 3'd0,
      PREPARA = 3'd1,
      MOSTRA  = 3'd2,
      APAGA   = 3'd3,
      PROXIMO = 3'd4,
      FINAL   = 3'd5
   } estado_t;

   estado_t          r_estado;
   estado_t          w_proximo_estado;
   logic    [3:0]    r_endereco;
   logic    [3:0]    w_endereco;
   logic    [3:0]    r_limite;
   logic    [3:0]    w_limite;
   logic    [TW-1:0] r_timer;
   logic    [TW-1:0] w_timer;

   // State, address, latched limit and timer registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values computed before the edge, independent of block order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado   <= INICIAL;
         r_endereco <= 4'd0;
         r_limite   <= 4'd0;
         r_timer    <= '0;
      end else begin
         r_estado   <= w_proximo_estado;
         r_endereco <= w_endereco;
         r_limite   <= w_limite;
         r_timer    <= w_timer;
      end
   end

   // Next-state logic plus the next values of address, limit and timer.
   // NOTE: every signal gets a hold default before the case, so branches that
   // do not touch it keep the register value instead of inferring a latch.
   always_comb begin
      w_proximo_estado = r_estado;
      w_endereco       = r_endereco;
      w_limite         = r_limite;
      w_timer          = r_timer;

      case (r_estado)
         INICIAL: begin
            if (iniciar) w_proximo_estado = PREPARA;
         end

         PREPARA: begin
            w_proximo_estado = MOSTRA;
            w_endereco       = 4'd0;
            w_limite         = limite;
            w_timer          = '0;
         end

         MOSTRA: begin
            if (r_timer == ON_LAST) begin
               w_proximo_estado = APAGA;
               w_timer          = '0;
            end else begin
               w_timer = r_timer + TW'(1);
            end
         end

         APAGA: begin
            if (r_timer == OFF_LAST) begin
               w_timer          = '0;
               w_proximo_estado = (r_endereco == r_limite) ? FINAL : PROXIMO;
            end else begin
               w_timer = r_timer + TW'(1);
            end
         end

         PROXIMO: begin
            w_proximo_estado = MOSTRA;
            w_endereco       = r_endereco + 4'd1;
            w_timer          = '0;
         end

         FINAL: begin
            if (iniciar) w_proximo_estado = PREPARA;
         end

         default: begin
            w_proximo_estado = INICIAL;
         end
      endcase
   end

   // Moore outputs decoded from the current state only.
   always_comb begin
      leds      = 4'b0000;
      exibindo  = 1'b0;
      pronto    = 1'b0;
      db_estado = 4'b1111;

      case (r_estado)
         INICIAL: db_estado = 4'b0000;
         PREPARA: begin
            db_estado = 4'b0001;
            exibindo  = 1'b1;
         end
         MOSTRA: begin
            db_estado = 4'b0010;
            exibindo  = 1'b1;
            leds      = dado;
         end
         APAGA: begin
            db_estado = 4'b0011;
            exibindo  = 1'b1;
         end
         PROXIMO: begin
            db_estado = 4'b0100;
            exibindo  = 1'b1;
         end
         FINAL: begin
            db_estado = 4'b0101;
            pronto    = 1'b1;
         end
         default: db_estado = 4'b1111;
      endcase
   end

   assign endereco = r_endereco;

endmodule

// File: tb/tb_unidade_exibicao_sequencia.sv
// Testbench for unidade_exibicao_sequencia with T_ON=4, T_OFF=2.
// A table of playback runs {limite, expected latency, disturbance flag} is
// replayed against a behavioural memory; hand-written sequences cover reset
// and idle behaviour.
module tb_unidade_exibicao_sequencia;

   localparam int T_ON  = 4;
   localparam int T_OFF = 2;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic [3:0] limite;
   logic [3:0] dado;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       exibindo;
   logic       pronto;
   logic [3:0] db_estado;

   logic [3:0] mem [16];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] lim;
      int         lat;
      logic       disturb;
   } vec_t;

   vec_t tbl [4];

   unidade_exibicao_sequencia #(
      .T_ON (T_ON),
      .T_OFF(T_OFF)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .iniciar  (iniciar),
      .limite   (limite),
      .dado     (dado),
      .endereco (endereco),
      .leds     (leds),
      .exibindo (exibindo),
      .pronto   (pronto),
      .db_estado(db_estado)
   );

   // Asynchronous-read memory model.
   assign dado = mem[endereco];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Start a playback from inicial/final and follow it edge by edge up to final.
   task automatic play(input logic [3:0] lim, input int exp_lat, input logic disturb);
      int n;
      limite  = lim;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      n = 0;
      check("prepara_estado", {4'd0, db_estado}, 8'd1);
      check("prepara_exibindo", {7'd0, exibindo}, 8'd1);
      check("prepara_pronto", {7'd0, pronto}, 8'd0);
      check("prepara_leds", {4'd0, leds}, 8'd0);
      for (int k = 0; k <= int'(lim); k++) begin
         for (int t = 0; t < T_ON; t++) begin
            tick();
            n++;
            check("mostra_estado", {4'd0, db_estado}, 8'd2);
            check("mostra_leds", {4'd0, leds}, {4'd0, mem[k]});
            check("mostra_endereco", {4'd0, endereco}, 8'(k));
            check("mostra_exibindo", {7'd0, exibindo}, 8'd1);
            if (disturb && k == 0 && t == 1) iniciar = 1'b1;
            if (disturb && k == 0 && t == 2) iniciar = 1'b0;
         end
         for (int t = 0; t < T_OFF; t++) begin
            tick();
            n++;
            check("apaga_estado", {4'd0, db_estado}, 8'd3);
            check("apaga_leds", {4'd0, leds}, 8'd0);
            check("apaga_endereco", {4'd0, endereco}, 8'(k));
            if (disturb && k == 0 && t == 0) limite = 4'd5;
         end
         if (k < int'(lim)) begin
            tick();
            n++;
            check("proximo_estado", {4'd0, db_estado}, 8'd4);
            check("proximo_leds", {4'd0, leds}, 8'd0);
            check("proximo_pronto", {7'd0, pronto}, 8'd0);
         end
      end
      tick();
      n++;
      check("final_estado", {4'd0, db_estado}, 8'd5);
      check("final_pronto", {7'd0, pronto}, 8'd1);
      check("final_exibindo", {7'd0, exibindo}, 8'd0);
      check("final_endereco", {4'd0, endereco}, {4'd0, lim});
      check("latencia", 8'(n), 8'(exp_lat));
      // Idle in final: state and address must hold.
      repeat (2) tick();
      check("final_hold_estado", {4'd0, db_estado}, 8'd5);
      check("final_hold_endereco", {4'd0, endereco}, {4'd0, lim});
      check("final_hold_leds", {4'd0, leds}, 8'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mem[0]  = 4'h1; mem[1]  = 4'h2; mem[2]  = 4'h4; mem[3]  = 4'h8;
      mem[4]  = 4'h3; mem[5]  = 4'h6; mem[6]  = 4'hC; mem[7]  = 4'h9;
      mem[8]  = 4'h5; mem[9]  = 4'hA; mem[10] = 4'h7; mem[11] = 4'hE;
      mem[12] = 4'hD; mem[13] = 4'hB; mem[14] = 4'hF; mem[15] = 4'h8;

      // Latency = 1 + (L+1)*(T_ON+T_OFF) + L with T_ON+T_OFF = 6.
      tbl[0] = '{lim: 4'd2,  lat: 21,  disturb: 1'b0};
      tbl[1] = '{lim: 4'd0,  lat: 7,   disturb: 1'b0};
      tbl[2] = '{lim: 4'd15, lat: 112, disturb: 1'b0};
      tbl[3] = '{lim: 4'd2,  lat: 21,  disturb: 1'b1};

      reset   = 1'b1;
      iniciar = 1'b0;
      limite  = 4'd0;
      repeat (2) tick();
      check("reset_estado", {4'd0, db_estado}, 8'd0);
      check("reset_leds", {4'd0, leds}, 8'd0);
      check("reset_endereco", {4'd0, endereco}, 8'd0);
      check("reset_exibindo", {7'd0, exibindo}, 8'd0);
      check("reset_pronto", {7'd0, pronto}, 8'd0);
      reset = 1'b0;
      repeat (2) tick();
      check("inicial_hold", {4'd0, db_estado}, 8'd0);

      // Successive runs also exercise final -> prepara with a new limite.
      for (int i = 0; i < 4; i++) begin
         play(tbl[i].lim, tbl[i].lat, tbl[i].disturb);
      end

      // Reset in the middle of showing entry 1.
      limite  = 4'd2;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      repeat (9) tick();
      check("pre_reset_estado", {4'd0, db_estado}, 8'd2);
      check("pre_reset_endereco", {4'd0, endereco}, 8'd1);
      check("pre_reset_leds", {4'd0, leds}, 8'h2);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_estado", {4'd0, db_estado}, 8'd0);
      check("async_reset_leds", {4'd0, leds}, 8'd0);
      check("async_reset_endereco", {4'd0, endereco}, 8'd0);
      check("async_reset_pronto", {7'd0, pronto}, 8'd0);
      check("async_reset_exibindo", {7'd0, exibindo}, 8'd0);
      tick();
      reset = 1'b0;
      tick();
      check("post_reset_estado", {4'd0, db_estado}, 8'd0);
      play(4'd1, 14, 1'b0);

      // iniciar held high in final restarts at once.
      limite  = 4'd0;
      iniciar = 1'b1;
      tick();
      check("restart_prepara", {4'd0, db_estado}, 8'd1);
      check("restart_pronto", {7'd0, pronto}, 8'd0);
      repeat (7) tick();
      check("restart_final", {4'd0, db_estado}, 8'd5);
      tick();
      check("restart_again", {4'd0, db_estado}, 8'd1);
      iniciar = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/unidade_exibicao_sequencia.md
Name: unidade_exibicao_sequencia

Overview:
Playback side of the memory-game datapath: before the player echoes a round, this block reads the stored sequence from the external jogadas memory. It reads entries 0..limite in order and shows each on the LEDs for a fixed lit time, followed by a fixed dark gap. When the whole sequence has been shown, it raises pronto so the game control unit can enter its wait-for-play state.

Parameters:
T_ON, 1000, clock cycles each entry is shown on leds (must be >= 1)
T_OFF, 500, clock cycles leds are dark after each entry (must be >= 1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces state inicial
iniciar  input  1  start playback; sampled only in inicial and final
limite  input  4  index of last entry to show (0..15); latched in prepara
dado  input  4  memory read data for endereco (combinational/async read)
endereco  output  4  memory address being shown
leds  output  4  displayed value; dado while lit, 0000 otherwise
exibindo  output  1  high while playback is in progress (prepara, mostra, apaga, proximo)
pronto  output  1  high in final
db_estado  output  4  debug state code

Behaviour:
- Reset (async, any time, including mid-playback): state inicial, endereco=0, limite register=0, timer=0, leds=0000, exibindo=0, pronto=0.
- States / db_estado codes: inicial 0000, prepara 0001, mostra 0010, apaga 0011, proximo 0100, final 0101. Any illegal code goes to inicial; its db_estado is 1111.
- Transitions:
  - inicial: iniciar=1 -> prepara; else stay.
  - prepara: always -> mostra. On exit: endereco<=0, limite latched, timer<=0.
  - mostra: timer==T_ON-1 -> apaga (timer<=0); else timer++.
  - apaga: if timer==T_OFF-1, go to final when endereco==limite register, otherwise proximo; timer<=0 on exit. Else timer++.
  - proximo: endereco++ and timer<=0, -> mostra.
  - final: iniciar=1 -> prepara; else stay. endereco holds its last value.
- Outputs are Moore only:
  - leds = dado only in mostra, else 0000.
  - Each entry is lit for exactly T_ON cycles and dark for exactly T_OFF cycles.
- Latency: from the edge that samples iniciar to the edge entering final = 1 + (L+1)*(T_ON+T_OFF) + L cycles, where L = latched limite.
- Inputs ignored during playback:
  - iniciar is ignored in prepara, mostra, apaga and proximo.
  - Changes to limite after prepara have no effect until the next start.
- endereco never wraps: with limite=15, playback ends in final from endereco 15.
- Timer width is sized for max(T_ON, T_OFF); the timer never exceeds its terminal value.
- If iniciar is held high in final, a new playback restarts immediately (final -> prepara).

Test Plan:
- Bench parameters T_ON=4, T_OFF=2 for all scenarios.
- Reset, then iniciar pulse with limite=2 and memory {0001,0010,0100,…} -> leds shows 0001 for 4 cycles, 0000 for 2, 0010 for 4, 0000 for 2, 0100 for 4, 0000 for 2; pronto rises exactly 21 cycles after the sampling edge; endereco=2.
- limite=0 -> one entry shown, 4 lit + 2 dark; final reached after 7 cycles; exibindo high only during those cycles.
- limite=15 -> all 16 entries shown in order 0..15; final reached after 1+16*6+15=112 cycles; endereco stays 15 (no wrap).
- iniciar pulsed during mostra, and limite changed from 2 to 5 during apaga -> playback is unaffected and ends after entry 2.
- Reset asserted mid-mostra at endereco=1 -> immediately db_estado=0000, leds=0000, endereco=0, pronto=0; a later iniciar replays from entry 0.
- In final, iniciar=1 -> prepara on the next edge, pronto drops, and the sequence replays with the newly latched limite.
